// File: rtl/tcm_arb_pkg.sv
// Shared types for the TCM port arbiter: arbitration state, read-return
// owner tag, requester payload bundle and the write-mask helper.
package tcm_arb_pkg;

    // Widest port the payload bundle carries; the top narrows to its own widths.
    localparam int TCM_ADDR_W = 12;
    localparam int TCM_DATA_W = 32;
    localparam int TCM_BE_W   = TCM_DATA_W / 8;

    typedef enum logic [0:0] {
        PRIO_LSU = 1'b0,
        PRIO_LDR = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_LSU  = 2'b01,
        OWN_LDR  = 2'b10
    } rd_owner_t;

    typedef struct packed {
        logic                  we;
        logic [TCM_ADDR_W-1:0] addr;
        logic [TCM_DATA_W-1:0] wdata;
        logic [TCM_BE_W-1:0]   be;
    } tcm_req_t;

    // Byte write enables seen by the memory: the byte enables on a write,
    // all zero on a read so a stray be never corrupts memory.
    function automatic logic [TCM_BE_W-1:0] write_mask(input tcm_req_t req);
        logic [TCM_BE_W-1:0] mask;
        if (req.we) begin
            mask = req.be;
        end else begin
            mask = {TCM_BE_W{1'b0}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/tcm_arb_starve_counter.sv
// Saturating loader-starvation counter. Counts consecutive denied loader
// cycles, clears on demand, and flags when the next count hits the limit so
// the arbiter can flip priority in time for the following cycle.
module tcm_arb_starve_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic limit_o
);
    import tcm_arb_pkg::*;

    localparam int                CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (inc_i && (count_q != LIMIT_C)) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Limit is judged on the next count so priority changes at the same edge.
    assign limit_o = (count_d == LIMIT_C);

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Arbiter for the single TCM read/write port shared by the core load/store
// path and the external program loader. One access per cycle, core has
// priority, the loader is guaranteed progress by a starvation counter, and
// read data returns one cycle after the granted strobe to whoever issued it.
module tcm_port_arbiter
    import tcm_arb_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int BE_W         = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic [BE_W-1:0]   lsu_be_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [DATA_W-1:0] lsu_rdata_o,

    input  logic              ldr_req_i,
    input  logic              ldr_we_i,
    input  logic [ADDR_W-1:0] ldr_addr_i,
    input  logic [DATA_W-1:0] ldr_wdata_i,
    input  logic [BE_W-1:0]   ldr_be_i,
    output logic              ldr_gnt_o,
    output logic              ldr_rvalid_o,
    output logic [DATA_W-1:0] ldr_rdata_o,

    output logic              mem_en_o,
    output logic [BE_W-1:0]   mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    arb_state_t state_q;
    rd_owner_t  rd_owner_q;

    logic       lsu_gnt_s;
    logic       ldr_gnt_s;
    logic       starve_inc_s;
    logic       starve_clr_s;
    logic       reach_limit_s;

    tcm_req_t   lsu_pl_s;
    tcm_req_t   ldr_pl_s;
    tcm_req_t   sel_pl_s;

    // Bundle each requester's payload into the common request shape.
    always_comb begin
        lsu_pl_s.we    = lsu_we_i;
        lsu_pl_s.addr  = TCM_ADDR_W'(lsu_addr_i);
        lsu_pl_s.wdata = TCM_DATA_W'(lsu_wdata_i);
        lsu_pl_s.be    = TCM_BE_W'(lsu_be_i);
        ldr_pl_s.we    = ldr_we_i;
        ldr_pl_s.addr  = TCM_ADDR_W'(ldr_addr_i);
        ldr_pl_s.wdata = TCM_DATA_W'(ldr_wdata_i);
        ldr_pl_s.be    = TCM_BE_W'(ldr_be_i);
    end

    // Grant decision: the prioritised requester wins, a lone requester is
    // always served, and nothing is granted while reset is asserted.
    always_comb begin
        lsu_gnt_s = 1'b0;
        ldr_gnt_s = 1'b0;
        if (rst_i) begin
            lsu_gnt_s = 1'b0;
            ldr_gnt_s = 1'b0;
        end else begin
            case (state_q)
                PRIO_LSU: begin
                    lsu_gnt_s = lsu_req_i;
                    ldr_gnt_s = ldr_req_i & ~lsu_req_i;
                end
                PRIO_LDR: begin
                    ldr_gnt_s = ldr_req_i;
                    lsu_gnt_s = lsu_req_i & ~ldr_req_i;
                end
                default: begin
                    lsu_gnt_s = 1'b0;
                    ldr_gnt_s = 1'b0;
                end
            endcase
        end
    end

    assign lsu_gnt_o = lsu_gnt_s;
    assign ldr_gnt_o = ldr_gnt_s;

    // A denied loader request counts towards starvation; any grant, an idle
    // loader, or the single loader-priority cycle restarts the count.
    assign starve_inc_s = ldr_req_i & ~ldr_gnt_s;
    assign starve_clr_s = ldr_gnt_s | ~ldr_req_i | (state_q == PRIO_LDR);

    tcm_arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (starve_clr_s),
        .inc_i   (starve_inc_s),
        .limit_o (reach_limit_s)
    );

    // Memory payload follows whichever requester holds the grant.
    always_comb begin
        if (ldr_gnt_s) begin
            sel_pl_s = ldr_pl_s;
        end else begin
            sel_pl_s = lsu_pl_s;
        end
    end

    assign mem_en_o    = lsu_gnt_s | ldr_gnt_s;
    assign mem_we_o    = mem_en_o ? BE_W'(write_mask(sel_pl_s)) : {BE_W{1'b0}};
    assign mem_addr_o  = ADDR_W'(sel_pl_s.addr);
    assign mem_wdata_o = DATA_W'(sel_pl_s.wdata);

    // Priority FSM and read-return owner tag; loader priority lasts exactly
    // until its transfer completes or it withdraws its request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= PRIO_LSU;
            rd_owner_q <= OWN_NONE;
        end else begin
            case (state_q)
                PRIO_LSU: begin
                    if (reach_limit_s) begin
                        state_q <= PRIO_LDR;
                    end else begin
                        state_q <= PRIO_LSU;
                    end
                end
                PRIO_LDR: begin
                    if (ldr_gnt_s || !ldr_req_i) begin
                        state_q <= PRIO_LSU;
                    end else begin
                        state_q <= PRIO_LDR;
                    end
                end
                default: begin
                    state_q <= PRIO_LSU;
                end
            endcase

            if (lsu_gnt_s && !lsu_we_i) begin
                rd_owner_q <= OWN_LSU;
            end else if (ldr_gnt_s && !ldr_we_i) begin
                rd_owner_q <= OWN_LDR;
            end else begin
                rd_owner_q <= OWN_NONE;
            end
        end
    end

    // Return path: the memory's read data goes to the owner of last cycle's
    // read and is held at zero on the other side.
    assign lsu_rvalid_o = (rd_owner_q == OWN_LSU);
    assign ldr_rvalid_o = (rd_owner_q == OWN_LDR);
    assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : {DATA_W{1'b0}};
    assign ldr_rdata_o  = ldr_rvalid_o ? mem_rdata_i : {DATA_W{1'b0}};

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed bench for tcm_port_arbiter: a cycle table of hand-computed
// expectations plus sequences for reset, starvation and reset-mid-read.
module tb_tcm_port_arbiter;
    import tcm_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req, lsu_we, ldr_req, ldr_we;
    logic [11:0] lsu_addr, ldr_addr;
    logic [31:0] lsu_wdata, ldr_wdata;
    logic [3:0]  lsu_be, ldr_be;
    logic        lsu_gnt, lsu_rvalid, ldr_gnt, ldr_rvalid;
    logic [31:0] lsu_rdata, ldr_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    tcm_port_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
        .lsu_wdata_i(lsu_wdata), .lsu_be_i(lsu_be), .lsu_gnt_o(lsu_gnt),
        .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
        .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr),
        .ldr_wdata_i(ldr_wdata), .ldr_be_i(ldr_be), .ldr_gnt_o(ldr_gnt),
        .ldr_rvalid_o(ldr_rvalid), .ldr_rdata_o(ldr_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // Synchronous-read memory with byte writes.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            if (mem_we == 4'h0) mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic lreq; logic lwe; logic [11:0] laddr; logic [31:0] lwdata; logic [3:0] lbe;
        logic dreq; logic dwe; logic [11:0] daddr; logic [31:0] dwdata; logic [3:0] dbe;
        logic lg; logic dg; logic en; logic [3:0] we; logic [11:0] addr;
        logic lrv; logic [31:0] lrd; logic drv; logic [31:0] drd;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic lr, input logic lw, input logic [11:0] la, input logic [31:0] ld, input logic [3:0] lb,
                         input logic dr, input logic dw, input logic [11:0] da, input logic [31:0] dd, input logic [3:0] db);
        lsu_req = lr; lsu_we = lw; lsu_addr = la; lsu_wdata = ld; lsu_be = lb;
        ldr_req = dr; ldr_we = dw; ldr_addr = da; ldr_wdata = dd; ldr_be = db;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        //           lsu: req we addr wdata be        ldr: req we addr wdata be           exp: lg dg en we addr     lrv lrd            drv drd
        vecs[0]  = '{1'b0,1'b0,12'h000,32'h0,4'h0,        1'b1,1'b1,12'h010,32'hDEADBEEF,4'hF, 1'b0,1'b1,1'b1,4'hF,12'h010, 1'b0,32'h0,        1'b0,32'h0};
        vecs[1]  = '{1'b0,1'b0,12'h000,32'h0,4'h0,        1'b1,1'b1,12'h001,32'hA5A50001,4'hF, 1'b0,1'b1,1'b1,4'hF,12'h001, 1'b0,32'h0,        1'b0,32'h0};
        vecs[2]  = '{1'b0,1'b0,12'h000,32'h0,4'h0,        1'b1,1'b1,12'h002,32'h5A5A0002,4'hF, 1'b0,1'b1,1'b1,4'hF,12'h002, 1'b0,32'h0,        1'b0,32'h0};
        vecs[3]  = '{1'b0,1'b0,12'h000,32'h0,4'h0,        1'b1,1'b0,12'h010,32'h0,4'h0,        1'b0,1'b1,1'b1,4'h0,12'h010, 1'b0,32'h0,        1'b0,32'h0};
        vecs[4]  = '{1'b1,1'b1,12'h020,32'h11223344,4'hF, 1'b0,1'b0,12'h000,32'h0,4'h0,        1'b1,1'b0,1'b1,4'hF,12'h020, 1'b0,32'h0,        1'b1,32'hDEADBEEF};
        vecs[5]  = '{1'b1,1'b1,12'h020,32'h0000AB00,4'h2, 1'b0,1'b0,12'h000,32'h0,4'h0,        1'b1,1'b0,1'b1,4'h2,12'h020, 1'b0,32'h0,        1'b0,32'h0};
        vecs[6]  = '{1'b1,1'b0,12'h020,32'h0,4'h0,        1'b0,1'b0,12'h000,32'h0,4'h0,        1'b1,1'b0,1'b1,4'h0,12'h020, 1'b0,32'h0,        1'b0,32'h0};
        vecs[7]  = '{1'b1,1'b0,12'h001,32'hFFFFFFFF,4'hF, 1'b0,1'b0,12'h000,32'h0,4'h0,        1'b1,1'b0,1'b1,4'h0,12'h001, 1'b1,32'h1122AB44, 1'b0,32'h0};
        vecs[8]  = '{1'b0,1'b0,12'h000,32'h0,4'h0,        1'b1,1'b0,12'h002,32'h0,4'h0,        1'b0,1'b1,1'b1,4'h0,12'h002, 1'b1,32'hA5A50001, 1'b0,32'h0};
        vecs[9]  = '{1'b1,1'b0,12'h002,32'h0,4'h0,        1'b0,1'b0,12'h000,32'h0,4'h0,        1'b1,1'b0,1'b1,4'h0,12'h002, 1'b0,32'h0,        1'b1,32'h5A5A0002};
        vecs[10] = '{1'b1,1'b0,12'h010,32'h0,4'h0,        1'b1,1'b0,12'h001,32'h0,4'h0,        1'b1,1'b0,1'b1,4'h0,12'h010, 1'b1,32'h5A5A0002, 1'b0,32'h0};
        vecs[11] = '{1'b0,1'b0,12'h000,32'h0,4'h0,        1'b1,1'b0,12'h001,32'h0,4'h0,        1'b0,1'b1,1'b1,4'h0,12'h001, 1'b1,32'hDEADBEEF, 1'b0,32'h0};
        vecs[12] = '{1'b0,1'b0,12'h000,32'h0,4'h0,        1'b0,1'b0,12'h000,32'h0,4'h0,        1'b0,1'b0,1'b0,4'h0,12'h000, 1'b0,32'h0,        1'b1,32'hA5A50001};

        // Reset with both requesters asking: nothing may reach the memory.
        rst = 1'b1;
        drive(1'b1, 1'b1, 12'h3FF, 32'h0, 4'hF, 1'b1, 1'b1, 12'h3FE, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        #2;
        chk("rst lsu_gnt", 32'(lsu_gnt), 32'h0);
        chk("rst ldr_gnt", 32'(ldr_gnt), 32'h0);
        chk("rst mem_en", 32'(mem_en), 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'h0);
        chk("rst lsu_rvalid", 32'(lsu_rvalid), 32'h0);
        chk("rst ldr_rvalid", 32'(ldr_rvalid), 32'h0);
        chk("rst state", 32'(dut.state_q), 32'(PRIO_LSU));
        chk("rst starve_cnt", 32'(dut.u_starve.count_q), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("post-rst lsu_gnt", 32'(lsu_gnt), 32'h1);
        chk("post-rst ldr_gnt", 32'(ldr_gnt), 32'h0);
        chk("post-rst mem_we", 32'(mem_we), 32'hF);
        chk("post-rst mem_addr", 32'(mem_addr), 32'h3FF);
        @(negedge clk);
        idle();
        #2;
        chk("write no rvalid", 32'(lsu_rvalid), 32'h0);

        // Cycle table.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].lreq, vecs[i].lwe, vecs[i].laddr, vecs[i].lwdata, vecs[i].lbe,
                  vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwdata, vecs[i].dbe);
            #2;
            chk($sformatf("row%0d lsu_gnt", i), 32'(lsu_gnt), 32'(vecs[i].lg));
            chk($sformatf("row%0d ldr_gnt", i), 32'(ldr_gnt), 32'(vecs[i].dg));
            chk($sformatf("row%0d mem_en", i), 32'(mem_en), 32'(vecs[i].en));
            chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(vecs[i].we));
            if (vecs[i].en) chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("row%0d lsu_rvalid", i), 32'(lsu_rvalid), 32'(vecs[i].lrv));
            chk($sformatf("row%0d lsu_rdata", i), lsu_rdata, vecs[i].lrd);
            chk($sformatf("row%0d ldr_rvalid", i), 32'(ldr_rvalid), 32'(vecs[i].drv));
            chk($sformatf("row%0d ldr_rdata", i), ldr_rdata, vecs[i].drd);
        end

        // Sustained contention: core for 8 cycles, loader on cycle 9, core again.
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 12'h003, 32'h0, 4'h0, 1'b1, 1'b0, 12'h004, 32'h0, 4'h0);
            #2;
            chk($sformatf("starve c%0d lsu_gnt", c), 32'(lsu_gnt), (c == 9) ? 32'h0 : 32'h1);
            chk($sformatf("starve c%0d ldr_gnt", c), 32'(ldr_gnt), (c == 9) ? 32'h1 : 32'h0);
            chk($sformatf("starve c%0d lsu_rvalid", c), 32'(lsu_rvalid), (c >= 2 && c != 10) ? 32'h1 : 32'h0);
            chk($sformatf("starve c%0d ldr_rvalid", c), 32'(ldr_rvalid), (c == 10) ? 32'h1 : 32'h0);
            if (c == 9) chk("starve c9 mem_addr", 32'(mem_addr), 32'h004);
        end
        @(negedge clk);
        idle();
        #2;
        chk("starve tail lsu_rvalid", 32'(lsu_rvalid), 32'h1);
        chk("starve tail ldr_rvalid", 32'(ldr_rvalid), 32'h0);

        // Loader withdraws in its priority cycle: priority returns to the core.
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 12'h005, 32'h0, 4'h0, (c != 9), 1'b0, 12'h006, 32'h0, 4'h0);
            #2;
            chk($sformatf("drop c%0d lsu_gnt", c), 32'(lsu_gnt), 32'h1);
            chk($sformatf("drop c%0d ldr_gnt", c), 32'(ldr_gnt), 32'h0);
        end
        @(negedge clk);
        idle();

        // Reset right after a granted core read squashes its return.
        @(negedge clk);
        drive(1'b1, 1'b0, 12'h001, 32'h0, 4'h0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        #2;
        chk("midrd lsu_gnt", 32'(lsu_gnt), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b0, 12'h001, 32'h0, 4'h0, 1'b1, 1'b0, 12'h002, 32'h0, 4'h0);
        @(negedge clk);
        #2;
        chk("midrd lsu_rvalid", 32'(lsu_rvalid), 32'h0);
        chk("midrd lsu_rdata", lsu_rdata, 32'h0);
        chk("midrd lsu_gnt in rst", 32'(lsu_gnt), 32'h0);
        chk("midrd ldr_gnt in rst", 32'(ldr_gnt), 32'h0);
        chk("midrd mem_en in rst", 32'(mem_en), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #2;
        chk("midrd post lsu_rvalid", 32'(lsu_rvalid), 32'h0);
        chk("midrd post ldr_rvalid", 32'(ldr_rvalid), 32'h0);
        chk("midrd state", 32'(dut.state_q), 32'(PRIO_LSU));
        chk("midrd starve_cnt", 32'(dut.u_starve.count_q), 32'h0);
        @(negedge clk);
        #2;
        chk("midrd late lsu_rvalid", 32'(lsu_rvalid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tcm_port_arbiter.md
# tcm_port_arbiter

Arbitrates the single read/write port of the core's tightly-coupled memory between two requesters: the core load/store path (MEMPREP issue, MEMEX return) and the external program loader. It issues at most one access per cycle with a fixed 1-cycle synchronous-read return, gives the core priority, and guarantees the loader forward progress through a starvation counter. A denied grant is the core's memory stall condition.

## Interface
- ADDR_W, 12, word-address width of the memory port
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8
- STARVE_LIMIT, 8, consecutive denied loader cycles before the loader gets priority (≥1)

- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- lsu_req / lsu_we  in  1  core access request / write (0 = read)
- lsu_addr  in  ADDR_W  core address
- lsu_wdata  in  DATA_W  core write data
- lsu_be  in  BE_W  core byte enables (writes only)
- lsu_gnt  out  1  core access accepted this cycle
- lsu_rvalid  out  1  core read data valid
- lsu_rdata  out  DATA_W  core read data
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_be, ldr_gnt, ldr_rvalid, ldr_rdata: same shape and meaning for the loader
- mem_en  out  1  memory access strobe
- mem_we  out  BE_W  per-byte write enable, zero on reads
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe

## Operation
- Handshake: a transfer occurs in a cycle where req & gnt. A requester holds req and all payload stable until granted. gnt is combinational from req and state; at most one gnt is high per cycle.
- mem_en = lsu_gnt | ldr_gnt. Memory payload is muxed from the granted requester. mem_we = be when we, else 0.
- FSM state arb_state_t, two states:
  - PRIO_LSU (reset): lsu_req wins. A lone ldr_req is granted.
  - PRIO_LDR: ldr_req wins. A lone lsu_req is granted.
- Starvation counter starve_cnt, width clog2(STARVE_LIMIT+1):
  - Increments when ldr_req & ~ldr_gnt.
  - Clears when ldr_gnt or ~ldr_req.
  - Saturates at STARVE_LIMIT.
- Transitions:
  - PRIO_LSU → PRIO_LDR when starve_cnt == STARVE_LIMIT.
  - PRIO_LDR → PRIO_LSU after one loader transfer, or when ldr_req drops; starve_cnt clears in both cases.
- Read return:
  - Registered rd_owner (NONE/LSU/LDR) records the requester of a granted read; writes record NONE.
  - Next cycle, the owner's rvalid = 1. Both rdata outputs pass mem_rdata straight through, qualified by rvalid.
  - Back-to-back reads by either requester pipeline at one per cycle.

## Timing
- Reset values:
  - state PRIO_LSU, starve_cnt 0, rd_owner NONE.
  - lsu_rvalid and ldr_rvalid 0.
  - lsu_gnt, ldr_gnt, mem_en and mem_we forced 0 while rst is high.
- Grant latency 0 cycles after req. Read data latency 1 cycle after grant. Write commits at the granted edge.
- Simultaneous requests in PRIO_LSU: lsu wins and the loader counter increments.
- With lsu_req continuously high and ldr_req high, the loader is granted on denied cycle STARVE_LIMIT+1, i.e. one cycle after the state change. That cycle, lsu_gnt = 0 and the core stalls.
- Reset mid-read: a pending rvalid is squashed; no rvalid follows reset deassertion.
- Loader and core writing the same address on different cycles: last granted write wins. No ordering beyond grant order.

## Structure
- Shared package tcm_arb_pkg:
  - arb_state_t enum {PRIO_LSU, PRIO_LDR}
  - rd_owner_t enum {OWN_NONE, OWN_LSU, OWN_LDR}
  - requester payload struct tcm_req_t {we, addr, wdata, be}
- One sub-module, tcm_arb_starve_counter: saturating counter with clear, increment and limit-reached output.
- FSM and grant logic live in the top module.

## Test plan
- Reset: rst = 1 with both reqs high → both gnt 0, mem_en 0, rvalid 0. Release → lsu granted first cycle.
- Lone loader write: addr 0x010, data 0xDEADBEEF, be 4'b1111 → ldr_gnt the same cycle, mem_we 4'hF. Subsequent loader read of 0x010 → ldr_rvalid next cycle with 0xDEADBEEF, lsu_rvalid 0.
- Contention with STARVE_LIMIT = 8: lsu_req and ldr_req held high → lsu granted 8 cycles, ldr granted on cycle 9, lsu granted again from cycle 10.
- Interleaved reads: lsu reads 0x001 and ldr reads 0x002 on consecutive cycles → rvalids alternate with the correct owners and data, no bubbles.
- Byte write: lsu write be 4'b0010, data 0x0000AB00 over 0x11223344 → readback 0x1122AB44.
- Reset asserted the cycle after a granted lsu read → lsu_rvalid never asserts; state PRIO_LSU, starve_cnt 0.
